// File: rtl/oled_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | oled_pkg : shared types and helpers for the OLED SPI arbiter              |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package oled_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      BUSY    = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   localparam int OLED_SPI_BYTE_W = 8;

   function automatic longint ms_to_cycles(input longint clk_freq, input longint ms);
      return (clk_freq * ms) / 1000;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_ff : W-bit multi-stage synchroniser with reset value                 |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module sync_ff #(
   parameter int           W       = 1,
   parameter int           STAGES  = 2,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [STAGES-1:0][W-1:0] stage_q;
   logic [STAGES-1:0][W-1:0] stage_d;

   always_comb begin
      stage_d = {stage_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= {STAGES{RST_VAL}};
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q = stage_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/oled_spi_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | oled_spi_arbiter : frame-boundary SPI bus arbiter with byte decode        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module oled_spi_arbiter
   import oled_pkg::*;
#(
   parameter int                 CLK_FREQ    = 12_000_000,
   parameter int                 NUM_SRC     = 2,
   parameter logic [NUM_SRC-1:0] ASYNC_MASK  = 2'b10,
   parameter int                 SYNC_STAGES = 2,
   parameter int                 GUARD_CYC   = 4,
   parameter int                 ROUND_ROBIN = 0,
   parameter logic               SCLK_IDLE   = 1'b1,
   parameter int                 CNT_W       = 16,
   parameter int                 ACT_MS      = 50
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_SRC-1:0]         src_req,
   input  logic [NUM_SRC-1:0]         src_sclk,
   input  logic [NUM_SRC-1:0]         src_sdin,
   input  logic [NUM_SRC-1:0]         src_cs_n,
   input  logic [NUM_SRC-1:0]         src_d_cn,
   output logic [NUM_SRC-1:0]         src_grant,
   output logic                       oled_sclk,
   output logic                       oled_sdin,
   output logic                       oled_cs,
   output logic                       oled_d_cn,
   output logic                       byte_stb,
   output logic [OLED_SPI_BYTE_W-1:0] byte_data,
   output logic                       byte_is_data,
   output logic [CNT_W-1:0]           byte_cnt,
   output logic                       frame_err,
   output logic                       act_led
);

   localparam int             OW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int             GW         = $clog2(GUARD_CYC + 2);
   localparam logic [GW-1:0]  GUARD_MAX  = GW'(GUARD_CYC);
   localparam longint         ACT_CYC    = ms_to_cycles(CLK_FREQ, ACT_MS);
   localparam int             ACT_W      = (ACT_CYC < 2) ? 1 : $clog2(ACT_CYC + 1);
   localparam logic [ACT_W-1:0] ACT_RELOAD = ACT_W'(ACT_CYC);
   localparam int             BW         = OLED_SPI_BYTE_W;

   // Source-side view after optional synchronisation
   logic [NUM_SRC-1:0] req_s, sclk_s, sdin_s, cs_n_s, d_cn_s;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      if (ASYNC_MASK[i]) begin : g_async
         logic [4:0] raw;
         logic [4:0] synced;
         assign raw = {src_req[i], src_sclk[i], src_sdin[i], src_cs_n[i], src_d_cn[i]};
         sync_ff #(
            .W       (5),
            .STAGES  (SYNC_STAGES),
            .RST_VAL ({1'b0, SCLK_IDLE, 1'b0, 1'b1, 1'b0})
         ) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (raw),
            .q     (synced)
         );
         assign {req_s[i], sclk_s[i], sdin_s[i], cs_n_s[i], d_cn_s[i]} = synced;
      end else begin : g_direct
         assign req_s[i]  = src_req[i];
         assign sclk_s[i] = src_sclk[i];
         assign sdin_s[i] = src_sdin[i];
         assign cs_n_s[i] = src_cs_n[i];
         assign d_cn_s[i] = src_d_cn[i];
      end
   end

   arb_state_t           state_q, state_d;
   logic [OW-1:0]        owner_q, owner_d;
   logic [GW-1:0]        guard_q, guard_d;
   logic [NUM_SRC-1:0]   grant_q, grant_d;
   logic                 sclk_q, sclk_d, sdin_q, sdin_d, cs_q, cs_d, d_cn_q, d_cn_d;
   logic                 sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [BW-1:0]        shift_q, shift_d, data_q, data_d;
   logic                 stb_q, stb_d, is_data_q, is_data_d, err_q, err_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ACT_W-1:0]     act_q, act_d;

   logic                 win_found;
   logic [OW-1:0]        win_idx, cand;
   int                   sum;
   logic [NUM_SRC-1:0]   own_mask;
   logic                 own_req, own_cs_n, others, leave, following;
   logic                 sclk_rise, cs_rise;

   assign own_mask  = NUM_SRC'(1) << owner_q;
   assign own_req   = req_s[owner_q];
   assign own_cs_n  = cs_n_s[owner_q];
   assign others    = |(req_s & ~own_mask);
   assign leave     = !own_req || ((ROUND_ROBIN != 0) && others);
   assign following = (state_q == GRANT) || (state_q == BUSY);

   // Round robin scans from the slot after the last owner; fixed priority takes lowest index
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      sum       = 0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         if (ROUND_ROBIN != 0) begin
            sum = int'(owner_q) + k;
            if (sum >= NUM_SRC) sum = sum - NUM_SRC;
         end else begin
            sum = k - 1;
         end
         cand = OW'(sum);
         if (!win_found && req_s[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      guard_d = guard_q;
      case (state_q)
         IDLE: begin
            guard_d = '0;
            if (win_found) begin
               owner_d = win_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            guard_d = '0;
            state_d = BUSY;
         end
         BUSY: begin
            if (!own_cs_n)                guard_d = '0;
            else if (guard_q != GUARD_MAX) guard_d = guard_q + 1'b1;
            // An owner mid-frame keeps the bus until cs_n has been idle for the full guard
            if (leave && own_cs_n && (guard_q == GUARD_MAX)) state_d = RELEASE;
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      grant_d = ((state_d == GRANT) || (state_d == BUSY)) ? (NUM_SRC'(1) << owner_d) : '0;
   end

   always_comb begin
      sclk_d = SCLK_IDLE;
      sdin_d = 1'b0;
      cs_d   = 1'b1;
      d_cn_d = 1'b0;
      if (following) begin
         sclk_d = sclk_s[owner_q];
         sdin_d = sdin_s[owner_q];
         cs_d   = cs_n_s[owner_q];
         d_cn_d = d_cn_s[owner_q];
      end
   end

   // Byte decode runs on the registered bus so it sees exactly what the panel sees
   assign sclk_rise = sclk_q && !sclk_prev_q && !cs_q;
   assign cs_rise   = cs_q && !cs_prev_q;

   always_comb begin
      sclk_prev_d = sclk_q;
      cs_prev_d   = cs_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      data_d      = data_q;
      is_data_d   = is_data_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      stb_d       = 1'b0;
      if (cs_rise) begin
         if (bit_cnt_q != 3'd0) err_d = 1'b1;
         bit_cnt_d = 3'd0;
      end else if (sclk_rise) begin
         shift_d = {shift_q[BW-2:0], sdin_q};
         if (bit_cnt_q == 3'd7) begin
            stb_d     = 1'b1;
            data_d    = {shift_q[BW-2:0], sdin_q};
            is_data_d = d_cn_q;
            cnt_d     = cnt_q + 1'b1;
            bit_cnt_d = 3'd0;
         end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
         end
      end
      act_d = stb_d ? ACT_RELOAD : ((act_q != '0) ? act_q - 1'b1 : act_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= OW'(NUM_SRC - 1);
         guard_q     <= '0;
         grant_q     <= '0;
         sclk_q      <= SCLK_IDLE;
         sdin_q      <= 1'b0;
         cs_q        <= 1'b1;
         d_cn_q      <= 1'b0;
         sclk_prev_q <= SCLK_IDLE;
         cs_prev_q   <= 1'b1;
         bit_cnt_q   <= 3'd0;
         shift_q     <= '0;
         data_q      <= '0;
         is_data_q   <= 1'b0;
         stb_q       <= 1'b0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         act_q       <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         guard_q     <= guard_d;
         grant_q     <= grant_d;
         sclk_q      <= sclk_d;
         sdin_q      <= sdin_d;
         cs_q        <= cs_d;
         d_cn_q      <= d_cn_d;
         sclk_prev_q <= sclk_prev_d;
         cs_prev_q   <= cs_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         is_data_q   <= is_data_d;
         stb_q       <= stb_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         act_q       <= act_d;
      end
   end

   assign src_grant    = grant_q;
   assign oled_sclk    = sclk_q;
   assign oled_sdin    = sdin_q;
   assign oled_cs      = cs_q;
   assign oled_d_cn    = d_cn_q;
   assign byte_stb     = stb_q;
   assign byte_data    = data_q;
   assign byte_is_data = is_data_q;
   assign byte_cnt     = cnt_q;
   assign frame_err    = err_q;
   assign act_led      = (act_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_oled_spi_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_oled_spi_arbiter : scoreboard bench for oled_spi_arbiter               |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_oled_spi_arbiter;

   localparam int CLK_FREQ  = 12_000;
   localparam int CNT_W     = 4;
   localparam int GUARD_CYC = 4;
   localparam int ACT_CYC   = 600;

   typedef struct packed {
      logic [7:0]       data;
      logic             is_data;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic [1:0] src_req, src_sclk, src_sdin, src_cs_n, src_d_cn;

   logic [1:0]       grant0, grant1;
   logic             sclk0, sdin0, cs0, dcn0, stb0, isd0, err0, act0;
   logic [7:0]       data0;
   logic [CNT_W-1:0] cnt0;
   logic             sclk1, sdin1, cs1, dcn1, stb1, isd1, err1, act1;
   logic [7:0]       data1;
   logic [CNT_W-1:0] cnt1;

   int               checks = 0;
   int               errors = 0;
   int               cyc = 0;
   int               last_stb_cyc = 0;
   exp_t             exp_q[$];
   exp_t             mon_e;
   logic [CNT_W-1:0] exp_cnt = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   oled_spi_arbiter #(
      .CLK_FREQ(CLK_FREQ), .NUM_SRC(2), .ASYNC_MASK(2'b10), .SYNC_STAGES(2),
      .GUARD_CYC(GUARD_CYC), .ROUND_ROBIN(0), .SCLK_IDLE(1'b1), .CNT_W(CNT_W), .ACT_MS(50)
   ) u_dut (
      .clk(clk), .reset(reset), .src_req(src_req), .src_sclk(src_sclk), .src_sdin(src_sdin),
      .src_cs_n(src_cs_n), .src_d_cn(src_d_cn), .src_grant(grant0), .oled_sclk(sclk0),
      .oled_sdin(sdin0), .oled_cs(cs0), .oled_d_cn(dcn0), .byte_stb(stb0), .byte_data(data0),
      .byte_is_data(isd0), .byte_cnt(cnt0), .frame_err(err0), .act_led(act0)
   );

   oled_spi_arbiter #(
      .CLK_FREQ(CLK_FREQ), .NUM_SRC(2), .ASYNC_MASK(2'b10), .SYNC_STAGES(2),
      .GUARD_CYC(GUARD_CYC), .ROUND_ROBIN(1), .SCLK_IDLE(1'b1), .CNT_W(CNT_W), .ACT_MS(50)
   ) u_dut_rr (
      .clk(clk), .reset(reset), .src_req(src_req), .src_sclk(src_sclk), .src_sdin(src_sdin),
      .src_cs_n(src_cs_n), .src_d_cn(src_d_cn), .src_grant(grant1), .oled_sclk(sclk1),
      .oled_sdin(sdin1), .oled_cs(cs1), .oled_d_cn(dcn1), .byte_stb(stb1), .byte_data(data1),
      .byte_is_data(isd1), .byte_cnt(cnt1), .frame_err(err1), .act_led(act1)
   );

   // Monitor: every byte strobe on the fixed-priority instance must match the head of the queue
   always @(negedge clk) begin
      if (!reset && stb0) begin
         last_stb_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL byte_unexpected got data=%02h is_data=%0d cnt=%0d required no byte",
                     data0, isd0, cnt0);
         end else begin
            mon_e = exp_q.pop_front();
            if ({data0, isd0, cnt0} !== mon_e) begin
               errors++;
               $display("FAIL byte got data=%02h is_data=%0d cnt=%0d required data=%02h is_data=%0d cnt=%0d",
                        data0, isd0, cnt0, mon_e.data, mon_e.is_data, mon_e.cnt);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h required=%0h", nm, got, exp);
      end
   endtask

   task automatic wait_grant0(input logic [1:0] exp, input string nm);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (grant0 !== exp && n < 200);
      check(nm, 32'(grant0), 32'(exp));
   endtask

   // Mode-3 style: data changes with sclk low, sampled on the rising edge, sclk = clk/6
   task automatic spi_bits(input int s, input logic [7:0] b, input int nbits, input logic dc);
      src_d_cn[s] = dc;
      for (int i = 7; i > 7 - nbits; i--) begin
         src_sclk[s] = 1'b0;
         src_sdin[s] = b[i];
         repeat (3) tick();
         src_sclk[s] = 1'b1;
         repeat (3) tick();
      end
   endtask

   task automatic send_byte(input int s, input logic [7:0] b, input logic dc);
      exp_t e;
      exp_cnt   = exp_cnt + 1'b1;
      e.data    = b;
      e.is_data = dc;
      e.cnt     = exp_cnt;
      exp_q.push_back(e);
      spi_bits(s, b, 8, dc);
   endtask

   initial begin
      int         n;
      int         nrec;
      int         bad;
      logic [1:0] prev;
      logic [1:0] rec [3];

      reset    = 1'b1;
      src_req  = 2'b00;
      src_sclk = 2'b11;
      src_sdin = 2'b00;
      src_cs_n = 2'b11;
      src_d_cn = 2'b00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      tick();
      check("rst_oled_cs",   32'(cs0),    32'(1));
      check("rst_oled_sclk", 32'(sclk0),  32'(1));
      check("rst_grant",     32'(grant0), 32'(0));
      check("rst_byte_cnt",  32'(cnt0),   32'(0));
      check("rst_frame_err", 32'(err0),   32'(0));
      check("rst_act_led",   32'(act0),   32'(0));

      // Sync source 0: one command byte 0xAF, then release
      src_req[0] = 1'b1;
      wait_grant0(2'b01, "src0_grant");
      src_cs_n[0] = 1'b0;
      n = 0;
      do begin tick(); n++; end while (cs0 !== 1'b0 && n < 20);
      check("sync_cs_latency", 32'(n), 32'(1));
      repeat (2) tick();
      send_byte(0, 8'hAF, 1'b0);
      repeat (3) tick();
      src_cs_n[0] = 1'b1;
      src_req[0]  = 1'b0;
      n = 0;
      do begin tick(); n++; end while (grant0 !== 2'b00 && n < 50);
      check("guard_release_cycles", 32'(n), 32'(GUARD_CYC + 1));
      repeat (2) tick();

      // Simultaneous requests: fixed priority holds src0, round robin alternates
      src_req = 2'b11;
      wait_grant0(2'b01, "fixed_prio_grant");
      prev = 2'b00;
      nrec = 0;
      bad  = 0;
      for (int i = 0; i < 80; i++) begin
         if (grant1 != 2'b00 && prev == 2'b00 && nrec < 3) begin
            rec[nrec] = grant1;
            nrec++;
         end
         prev = grant1;
         if (grant0 != 2'b01) bad++;
         tick();
      end
      check("rr_count",     32'(nrec), 32'(3));
      check("rr_grant_0",   32'(rec[0]), 32'(2'b01));
      check("rr_grant_1",   32'(rec[1]), 32'(2'b10));
      check("rr_grant_2",   32'(rec[2]), 32'(2'b01));
      check("fixed_hold",   32'(bad), 32'(0));
      src_req[0] = 1'b0;
      wait_grant0(2'b10, "handoff_to_src1");

      // Async source 1: three data bytes
      repeat (2) tick();
      src_cs_n[1] = 1'b0;
      n = 0;
      do begin tick(); n++; end while (cs0 !== 1'b0 && n < 20);
      check("async_cs_latency", 32'(n), 32'(3));
      repeat (2) tick();
      send_byte(1, 8'h5C, 1'b1);
      send_byte(1, 8'h00, 1'b1);
      send_byte(1, 8'hFF, 1'b1);
      repeat (3) tick();
      src_cs_n[1] = 1'b1;
      check("cnt_after_async", 32'(cnt0), 32'(4));
      n = 0;
      while (cyc != last_stb_cyc + ACT_CYC - 1 && n < 2000) begin tick(); n++; end
      check("act_led_held", 32'(act0), 32'(1));
      tick();
      check("act_led_expired", 32'(act0), 32'(0));
      src_req[1] = 1'b0;

      // Partial frame on src0, then a good byte
      src_req[0] = 1'b1;
      wait_grant0(2'b01, "src0_regrant");
      check("frame_err_clear", 32'(err0), 32'(0));
      repeat (2) tick();
      src_cs_n[0] = 1'b0;
      repeat (3) tick();
      spi_bits(0, 8'hA5, 5, 1'b0);
      src_cs_n[0] = 1'b1;
      repeat (4) tick();
      check("frame_err_set", 32'(err0), 32'(1));
      src_cs_n[0] = 1'b0;
      repeat (3) tick();
      send_byte(0, 8'h3C, 1'b1);
      repeat (3) tick();
      src_cs_n[0] = 1'b1;
      repeat (2) tick();
      check("frame_err_sticky", 32'(err0), 32'(1));
      check("cnt_after_partial", 32'(cnt0), 32'(5));

      // Reset in the middle of a byte
      src_cs_n[0] = 1'b0;
      repeat (3) tick();
      spi_bits(0, 8'hF0, 3, 1'b0);
      src_sclk[0] = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      check("midrst_cs",        32'(cs0),    32'(1));
      check("midrst_sclk",      32'(sclk0),  32'(1));
      check("midrst_grant",     32'(grant0), 32'(0));
      check("midrst_frame_err", 32'(err0),   32'(0));
      check("midrst_cnt",       32'(cnt0),   32'(0));
      src_cs_n = 2'b11;
      src_sclk = 2'b11;
      tick();
      reset   = 1'b0;
      exp_cnt = '0;
      exp_q.delete();

      // Counter wrap: 2^CNT_W bytes brings byte_cnt back to zero
      wait_grant0(2'b01, "post_reset_grant");
      repeat (2) tick();
      src_cs_n[0] = 1'b0;
      repeat (3) tick();
      for (int i = 0; i < 16; i++) begin
         send_byte(0, 8'(i * 17 + 3), 1'(i & 1));
      end
      repeat (3) tick();
      src_cs_n[0] = 1'b1;
      check("cnt_wrap", 32'(cnt0), 32'(0));
      check("no_err_after_wrap", 32'(err0), 32'(0));
      src_req[0] = 1'b0;

      n = 0;
      while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
      check("scoreboard_drain", 32'(exp_q.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
